// File: rtl/mem_access_seq.sv
// mem_access_seq: load/store sequencer in front of a byte-wide data memory.
// Word stores become four big-endian byte writes; loads are a single read
// whose result is registered. Each accepted request ends in a one-cycle
// response pulse, flagged as an error when the access runs past MEM_BYTES.
// Optional build macro: MEMSEQ_BYTE_SIGNEXT_EN (sign-extend byte loads).
module mem_access_seq #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic        mem_byte_src,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t      state_q;
  logic        byte_q;
  logic        err_q;
  logic [1:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic [32:0] req_end;
  logic        req_oob;
  logic        last_byte;
  logic [31:0] rd_ext;

  // Range check on the incoming request; 33 bits so a high address cannot wrap
  always_comb begin
    req_end = {1'b0, req_addr} + (req_byte ? 33'd1 : 33'd4);
    req_oob = (req_end > 33'(MEM_BYTES));
  end

  // Last byte of the current store and the width-adjusted load result
  always_comb begin
    last_byte = byte_q ? (cnt_q == 2'd0) : (cnt_q == 2'd3);
    if (byte_q) begin
`ifdef MEMSEQ_BYTE_SIGNEXT_EN
      rd_ext = {{24{mem_rd[7]}}, mem_rd[7:0]};
`else
      rd_ext = {24'b0, mem_rd[7:0]};
`endif
    end else begin
      rd_ext = mem_rd;
    end
  end

  // Request sequencing FSM; store/load direction is carried by the state
  // taken at acceptance, so the request's we bit needs no register of its own
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            byte_q  <= req_byte;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= '0;
            err_q   <= req_oob;
            if (req_oob)     state_q <= DONE;
            else if (req_we) state_q <= WRITE;
            else             state_q <= READ;
          end
        end
        WRITE: begin
          cnt_q <= cnt_q + 2'd1;
          if (last_byte) state_q <= DONE;
        end
        READ: begin
          rdata_q <= rd_ext;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte lane for the current write: big-endian, cnt 0 is bits [31:24]
  always_comb begin
    mem_wd = wdata_q[7:0];
    if (!byte_q) begin
      case (cnt_q)
        2'd0:    mem_wd = wdata_q[31:24];
        2'd1:    mem_wd = wdata_q[23:16];
        2'd2:    mem_wd = wdata_q[15:8];
        default: mem_wd = wdata_q[7:0];
      endcase
    end
  end

  // Handshake, response and memory-side outputs decoded from registered state
  always_comb begin
    req_ready    = reset_n && (state_q == IDLE);
    resp_valid   = (state_q == DONE);
    resp_err     = (state_q == DONE) && err_q;
    resp_rdata   = rdata_q;
    mem_we       = (state_q == WRITE);
    mem_byte_src = byte_q;
    mem_a        = addr_q + {30'b0, cnt_q};
  end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Memory access sequencer between the datapath's load/store interface and the byte-wide data memory. The memory commits only one byte per clock and returns a big-endian word, {RAM[a], RAM[a+1], RAM[a+2], RAM[a+3]}, or a zero-extended byte when `byte_src` is high. This block accepts one load or store request at a time through a ready/valid handshake. It splits word stores into four sequential byte writes, registers load data, and reports completion with a single-cycle response pulse.

## Interface
- `MEM_BYTES`, 256, memory size in bytes; accesses reaching at or beyond it are rejected.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access, 0 = word access.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; a byte store uses [7:0].
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: qualifies `resp_valid`; the access was out of range.
- `resp_rdata` out 32: load result, held until the next load completes.
- `mem_we` out 1: memory write enable.
- `mem_byte_src` out 1: memory byte-read select.
- `mem_a` out 32: memory address.
- `mem_wd` out 8: memory write byte.
- `mem_rd` in 32: memory read data (combinational).

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - `req_ready` = 1 (forced to 0 while `reset_n` = 0).
  - On `req_valid && req_ready`, the block captures we, byte, addr and wdata, and clears the byte counter `cnt`.
- Range check at acceptance:
  - Access length `len` = 1 for a byte access, 4 for a word access.
  - If `req_addr + len > MEM_BYTES` (33-bit compare, so no wrap), go to DONE with the error flag set and issue no memory access.
  - Otherwise a store goes to WRITE and a load goes to READ.
- WRITE:
  - `mem_we` = 1, `mem_a` = addr_q + cnt.
  - `mem_wd` = wdata_q[31-8*cnt -: 8] for a word store, wdata_q[7:0] for a byte store.
  - Ordering is big-endian: cnt 0 writes [31:24] to addr, and cnt 3 writes [7:0] to addr+3. A read-back therefore returns the stored word unchanged.
  - `cnt` increments every cycle. Exit to DONE after cnt = len-1.
- READ:
  - `mem_we` = 0, `mem_a` = addr_q, `mem_byte_src` = byte_q.
  - At the clock edge, `resp_rdata` captures `mem_rd` (with byte extension per Configuration). Then go to DONE.
- DONE:
  - `resp_valid` = 1 for exactly one cycle. `resp_err` = error flag. `req_ready` = 0.
  - Next state is IDLE. Back-to-back requests therefore cannot be accepted in consecutive cycles.
- Outside WRITE:
  - `mem_we` = 0.
  - `mem_a` = addr_q + cnt (combinational).
  - `mem_wd` follows the formula above.
  - `mem_byte_src` = byte_q.
- Stores leave `resp_rdata` unchanged. Error responses also leave `resp_rdata` unchanged.

## Timing
- Reset values (asynchronous):
  - State IDLE; addr_q, wdata_q, cnt and `resp_rdata` = 0.
  - Hence `mem_a` = 0, `mem_wd` = 0, `mem_we` = 0, `mem_byte_src` = 0.
  - `resp_valid` = 0, `resp_err` = 0, `req_ready` = 0 while reset is asserted.
- Acceptance edge E0 leads to:
  - Byte store: write committed at E1, `resp_valid` high in the cycle after E1.
  - Word store: byte writes committed at E1..E4, `resp_valid` high in the cycle after E4.
  - Load: data captured at E1, `resp_valid` and valid `resp_rdata` in the cycle after E1.
  - Error: `resp_valid` and `resp_err` high in the cycle after E0.
- `req_ready` returns high in the cycle after DONE.
- While `req_ready` = 0, `req_*` inputs are ignored.
- If reset asserts mid-WRITE, `mem_we` drops immediately and the FSM goes to IDLE. Bytes already committed stay in memory; there is no rollback and no response is issued.
- `resp_valid` is never asserted without a preceding accepted request.

## Configuration
- `MEMSEQ_BYTE_SIGNEXT_EN` defined: byte loads return {{24{mem_rd[7]}}, mem_rd[7:0]} (sign-extended).
- `MEMSEQ_BYTE_SIGNEXT_EN` undefined: byte loads return {24'b0, mem_rd[7:0]} (zero-extended).
- Word loads are unaffected in both builds.

## Test plan
- Reset, then word store addr=0x10, wdata=0xDEADBEEF:
  - `mem_we` high for 4 cycles.
  - Writes (0x10,DE), (0x11,AD), (0x12,BE), (0x13,EF).
  - `resp_valid` 1 cycle, `resp_err` = 0.
  - A following word load of 0x10 returns 0xDEADBEEF.
- Byte store addr=0x21, wdata=0x000000F0:
  - Single write (0x21,F0).
  - Byte load of 0x21 returns 0xFFFFFFF0 with `MEMSEQ_BYTE_SIGNEXT_EN` defined, 0x000000F0 without.
- Word store at addr=0xFD with MEM_BYTES=256:
  - `resp_err` = 1 in the cycle after acceptance.
  - No `mem_we` pulse; memory unchanged.
  - Byte access at 0xFF succeeds.
- `req_valid` held high continuously with new requests:
  - `req_ready` drops from acceptance through DONE.
  - Exactly one response per accepted request; no request lost or duplicated.
- Reset asserted after the second byte of a word store of 0x11223344 to 0x40:
  - `mem_we` falls immediately; no response.
  - Memory holds 0x11, 0x22 at 0x40-0x41; 0x42-0x43 keep their old values.
  - Outputs return to their reset values.
